// File: rtl/data_sram_ctrl.sv
// Data-side SRAM-like bus sequencer for the MEM stage: one load/store at a time, stalls until done.
// Optional bus watchdog is built in when DCTRL_TIMEOUT_EN is defined (adds the timeout_o port).
module data_sram_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pipe_stall_i,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        stallreq_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
`ifdef DCTRL_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);

    // state | meaning: IDLE no access | REQ address phase | WAIT data phase | DONE result held | DRAIN discard orphan data_ok
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        req_q;
    logic        tmo_fire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef DCTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_q;
    logic             tmo_hit;

    assign tmo_hit  = (tmo_cnt_q == '0);
    // Fires only when no normal transition (flush or handshake) claims the cycle.
    assign tmo_fire = tmo_hit &&
                      ((state_q == S_REQ   && !flush && !data_addr_ok) ||
                       (state_q == S_WAIT  && !flush && !data_data_ok) ||
                       (state_q == S_DRAIN && !data_data_ok));
    assign timeout_o = timeout_q;
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            we_q          <= 1'b0;
            size_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            req_q         <= 1'b0;
`ifdef DCTRL_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
`ifdef DCTRL_TIMEOUT_EN
            timeout_q <= tmo_fire;
            if ((state_q inside {S_REQ, S_WAIT, S_DRAIN}) && !tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q - CNT_W'(1);
            end
`endif
            case (state_q)
                S_IDLE: begin
                    rdata_valid_q <= 1'b0;
                    if (req_valid && !flush) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
`ifdef DCTRL_TIMEOUT_EN
                        tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        req_q   <= 1'b0;
                        state_q <= data_addr_ok ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end else if (tmo_fire) begin
                        req_q         <= 1'b0;
                        rdata_q       <= '0;
                        rdata_valid_q <= !we_q;
                        state_q       <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= data_data_ok ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok) begin
                        if (!we_q) begin
                            rdata_q <= data_rdata;
                        end
                        rdata_valid_q <= !we_q;
                        state_q       <= S_DONE;
                    end else if (tmo_fire) begin
                        rdata_q       <= '0;
                        rdata_valid_q <= !we_q;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || !pipe_stall_i) begin
                        rdata_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (data_data_ok || tmo_fire) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stallreq_o = (state_q == S_IDLE && req_valid && !flush) ||
                        (state_q == S_REQ) ||
                        (state_q == S_WAIT) ||
                        (state_q == S_DRAIN && req_valid);

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign data_req      = req_q;
    assign data_wr       = we_q;
    assign data_size     = size_q;
    assign data_addr     = addr_q;
    assign data_wdata    = wdata_q;
    assign data_wstrb    = wstrb_q;

endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Sequencing controller for the data-side SRAM-like bus of the dual-issue MIPS core; sits between EX/MEM and the data memory port.
- Accepts one load/store per MEM-stage instruction, drives the req/addr_ok/data_ok handshake and raises a stall request until the access completes.
- Cancels or drains in-flight accesses on exception flush, and hands the raw read word to the MEM stage for byte/half extension.

Parameters:
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; used only when DCTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- flush  in  1  exception/ERET flush from the exception logic
- pipe_stall_i  in  1  MEM held by another stall source
- req_valid  in  1  MEM instruction is a load/store with no exception
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word
- req_addr  in  32  physical byte address
- req_wdata  in  32  store data, lane-aligned
- req_wstrb  in  4  store byte enables
- stallreq_o  out  1  stall request to the pipeline controller
- rdata_o  out  32  raw read word
- rdata_valid_o  out  1  rdata_o holds the current load result
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_wstrb  out  4  bus byte strobes
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data / write ack
- data_rdata  in  32  bus read data
- timeout_o  out  1  watchdog pulse; present only with DCTRL_TIMEOUT_EN

Behaviour:
- Reset (synchronous, rst=1): state IDLE; all outputs and latched request registers 0.
- States: IDLE, REQ, WAIT, DONE, DRAIN. Bus outputs are driven from registers.

IDLE:
- If req_valid && !flush: latch we/size/addr/wdata/wstrb and go to REQ.
- stallreq_o is combinational: stallreq_o = (IDLE && req_valid && !flush) || REQ || WAIT || (DRAIN && req_valid).

REQ:
- data_req=1; address, data and control held stable until data_addr_ok.
- data_addr_ok && !flush -> WAIT.
- data_addr_ok && flush -> DRAIN.
- !data_addr_ok && flush -> IDLE; data_req drops the next cycle and the request is never accepted.

WAIT:
- data_req=0.
- data_data_ok && !flush -> DONE; for a load, rdata_o <= data_rdata.
- data_data_ok && flush -> IDLE; data discarded.
- flush without data_data_ok -> DRAIN.

DONE:
- stallreq_o=0; rdata_valid_o=1 for loads, 0 for stores; rdata_o held.
- pipe_stall_i=0 -> IDLE; rdata_valid_o=0 the next cycle.
- pipe_stall_i=1 -> remain in DONE, no reissue.
- flush -> IDLE.

DRAIN:
- Waits for the orphan data_data_ok; response discarded, rdata_o unchanged.
- data_data_ok -> IDLE.
- A new req_valid in DRAIN is stalled and is accepted from IDLE afterwards.

Bus and timing rules:
- data_data_ok never arrives in the same cycle as data_addr_ok; earliest is the cycle after. At most one outstanding transaction.
- Best-case load: accept cycle, REQ with addr_ok, data_ok the cycle after, then DONE; 3 stall cycles.
- Back-to-back accesses insert one IDLE cycle.
- flush has priority over every other transition in the same cycle.
- rst mid-transaction returns to IDLE without draining; the bus agent is reset by the same rst.
- Stores: data_rdata is ignored.
- No alignment check here; misaligned accesses arrive with req_valid=0 (ADEL/ADES raised upstream).

Optional Feature:
- Macro: DCTRL_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to REQ and counts each cycle spent in REQ, WAIT or DRAIN.
  - When the count reaches TIMEOUT_CYCLES: timeout_o pulses 1 cycle and data_req drops.
  - REQ/WAIT -> DONE with rdata_o=0; DRAIN -> IDLE.
- When undefined: no counter, no timeout_o port; the controller waits indefinitely.

Test Plan:
- Word load 0x8000_0010, addr_ok in REQ cycle 1, data_ok next cycle with 0x1234_5678 -> stallreq_o high 3 cycles, DONE: rdata_o=0x1234_5678, rdata_valid_o=1.
- Byte store addr 0x8000_0003, wdata 0xAA00_0000, wstrb 4'b1000, addr_ok delayed 4 cycles -> data_req held 5 cycles with stable addr/wstrb, data_wr=1, rdata_valid_o stays 0.
- flush in REQ before addr_ok -> next cycle IDLE, data_req=0, stallreq_o=0, no data_ok expected.
- flush in WAIT, data_ok 2 cycles later with new req_valid present -> DRAIN discards data, rdata_o unchanged, new request issued only after the drained data_ok.
- DONE with pipe_stall_i=1 for 3 cycles -> rdata_valid_o and rdata_o held, data_req stays 0 (no duplicate access).
- DCTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, addr_ok never asserted -> timeout_o pulse after 8 cycles, DONE with rdata_o=0, then IDLE.
